// File: rtl/start_conditioner_pkg.sv
// Shared types and defaults for the start-button front end feeding the bit-count core.
package start_conditioner_pkg;

    localparam int unsigned NUM_W_DEFAULT           = 10;
    localparam int unsigned SYNC_STAGES_DEFAULT     = 2;
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1_000_000;

    // Request sequencer states: a press is fired once, then held until release.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_RDY = 2'd1,
        ST_FIRE     = 2'd2,
        ST_HOLD     = 2'd3
    } state_t;

endpackage

// File: rtl/start_conditioner_sync_debounce.sv
// Synchronises one async button and accepts a new level only after it holds for
// DEBOUNCE_CYCLES consecutive synced samples; rise marks each accepted 0->1 change.
module start_conditioner_sync_debounce #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic stable,
    output logic rise
);

    localparam int unsigned    CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   din_s;
    logic [CNT_W-1:0]       cnt;

    assign din_s = sync_q[SYNC_STAGES-1];

    // Metastability chain; bit 0 is the first flop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    // Any return to the accepted level restarts the qualification window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            stable <= 1'b0;
            rise   <= 1'b0;
        end else begin
            rise <= 1'b0;
            if (din_s == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt    <= '0;
                stable <= din_s;
                rise   <= din_s;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/start_conditioner.sv
// Turns a bouncy start button and raw switches into a single START pulse with a
// stable switch snapshot, queueing one press while the downstream core is busy.
module start_conditioner
    import start_conditioner_pkg::*;
#(
    parameter int unsigned NUM_W           = NUM_W_DEFAULT,
    parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEFAULT,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_in,
    input  logic [NUM_W-1:0] sw_in,
    input  logic             busy,
    output logic             start,
    output logic [NUM_W-1:0] num_out,
    output logic             pending
);

    logic                              btn_stable;
    logic                              btn_rise;
    logic [SYNC_STAGES-1:0][NUM_W-1:0] sw_sync;
    logic [NUM_W-1:0]                  sw_s;
    state_t                            state_q;
    state_t                            state_d;

    start_conditioner_sync_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn (
        .clk    (clk),
        .rst_n  (rst_n),
        .din    (btn_in),
        .stable (btn_stable),
        .rise   (btn_rise)
    );

    // Switches are only synchronised; the snapshot is taken once per START
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_sync <= '0;
        end else begin
            sw_sync <= {sw_sync[SYNC_STAGES-2:0], sw_in};
        end
    end

    assign sw_s = sw_sync[SYNC_STAGES-1];

    // Busy sampled alongside rise decides between firing now and queueing
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (btn_rise) begin
                    state_d = busy ? ST_WAIT_RDY : ST_FIRE;
                end
            end
            ST_WAIT_RDY: begin
                if (!busy) begin
                    state_d = ST_FIRE;
                end
            end
            ST_FIRE: begin
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (!btn_stable) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decoded from the next state so they line up with the state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            start   <= 1'b0;
            pending <= 1'b0;
            num_out <= '0;
        end else begin
            state_q <= state_d;
            start   <= (state_d == ST_FIRE);
            pending <= (state_d == ST_WAIT_RDY);
            if (state_d == ST_FIRE) begin
                num_out <= sw_s;
            end
        end
    end

endmodule
